divider32_iter: RTL and testbench
=================================

// Module: divider32_iter
// PURPOSE
//  Iterative radix-2 restoring divider for the EX stage of the pipeline CPU (DIV/DIVU).
//  Produces a quotient and remainder that feed the EX-stage 32-bit result-select 2:1 mux.
//  Select=0 routes LO (quotient) and Select=1 routes HI (remainder) toward EX/MEM.
//  Hazard unit holds the pipeline while busy=1; result is latched until the next accepted start.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request; sampled only in IDLE
//  is_signed  in   1      1=DIV (two's complement), 0=DIVU; sampled with start
//  cancel     in   1      pipeline flush; aborts an operation in progress
//  dividend   in   WIDTH  sampled with start
//  divisor    in   WIDTH  sampled with start
//  busy       out  1      high from the cycle after accept until done falls
//  done       out  1      one-cycle pulse: quotient/remainder valid
//  quotient   out  WIDTH  registered quotient, held until next accepted start
//  remainder  out  WIDTH  registered remainder, held until next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, quotient=0, remainder=0, counter=0.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start=1 at edge T => latch operands (absolute values if is_signed) and record the sign flags;
//         enter CALC with count=0; busy=1 after T.
//   CALC: one shift/subtract step per edge, 32 edges (T+1..T+32); count wraps 31 -> FIX.
//   FIX:  edge T+33 applies the sign correction; quotient sign = sign(dividend) XOR sign(divisor);
//         remainder takes the sign of the dividend; -> DONE.
//   DONE: done=1, busy=1 for exactly the cycle after T+33; the next edge -> IDLE, done=0, busy=0.
//  Latency: start sampled at edge T => done high in cycle [T+33, T+34); fixed, data-independent.
//  start while not IDLE: ignored; no queueing.
//  start in the DONE cycle: ignored; a back-to-back op needs start in the following IDLE cycle.
//  cancel=1 in CALC/FIX: -> IDLE at the next edge; busy=0; done never pulses;
//   quotient/remainder keep their previous values.
//  cancel in IDLE: no effect, and start is not accepted that cycle (cancel wins).
//  cancel in DONE: done still pulses (result already final); consumer discards it.
//  Divide by zero (divisor=0, either mode): quotient=all ones, remainder=dividend.
//   Same 33-cycle latency, no exception.
//  Signed overflow (0x80000000 / 0xFFFFFFFF, is_signed=1): quotient=0x80000000, remainder=0.
//  Magnitude of 0x80000000 is handled as unsigned 2^31; the internal partial remainder is WIDTH+1 bits.
//  quotient/remainder update only on the FIX->DONE edge; stable at all other times.
//  Async reset mid-operation: immediate return to reset values; no partial result is visible.
// TESTING
//  1 DIVU 100/7: start at T -> done at T+33; quotient=14, remainder=2; busy high T+1..T+33.
//  2 DIV -7/2 (0xFFFFFFF9, 2): quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
//    DIV 7/-2: quotient=-3, remainder=1.
//  3 Div-by-zero 0x12345678/0 (both modes): quotient=0xFFFFFFFF, remainder=0x12345678, latency 33.
//  4 DIV 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0.
//    DIVU same operands: quotient=0, remainder=0x80000000.
//  5 start pulsed at T+5 and T+20 with new operands during op 1: op-1 results unchanged.
//    Single done at T+33; new start in IDLE afterwards is accepted normally.
//  6 cancel at T+10: busy=0 from T+11; no done; outputs keep prior values.
//    rst_n low at T+15 of a new op: all outputs 0 immediately.

Source files
------------

// File: rtl/divider32_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle, sign fix-up, fixed 33-cycle latency.
module divider32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] dvnd;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] rem_mag;

  assign accept  = (state == IDLE) && start && !cancel;
  assign last    = (count == CW'(WIDTH - 1));
  assign a_mag   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag   = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
  assign shifted = {part[WIDTH-1:0], quo[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvsr};
  assign rem_mag = part[WIDTH-1:0];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cancel)    state_nx = IDLE;
        else if (last) state_nx = FIX;
      end
      FIX: begin
        busy = 1'b1;
        if (cancel) state_nx = IDLE;
        else        state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand capture and shift/subtract iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      part  <= '0;
      quo   <= '0;
      dvsr  <= '0;
      dvnd  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (accept) begin
      count <= '0;
      part  <= '0;
      quo   <= a_mag;
      dvsr  <= b_mag;
      dvnd  <= dividend;
      neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= is_signed && dividend[WIDTH-1];
      dz    <= (divisor == '0);
    end else if (state == CALC && !cancel) begin
      count <= count + CW'(1);
      if (!diff[WIDTH+1]) begin
        part <= diff[WIDTH:0];
        quo  <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        part <= shifted;
        quo  <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // result registers: written only on the FIX->DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (state == FIX && !cancel) begin
      if (dz) begin
        quotient  <= '1;
        remainder <= dvnd;
      end else begin
        quotient  <= neg_q ? -quo : quo;
        remainder <= neg_r ? -rem_mag : rem_mag;
      end
    end
  end

endmodule

// File: tb/tb_divider32_iter.sv
// Directed bench for divider32_iter.
// Latency, sign rules, div-by-zero, overflow, cancel and reset.
module tb_divider32_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_cmp;
  int n_bad;
  int done_cnt;

  divider32_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .cancel    (cancel),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count done pulses away from the active edge
  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // one op; optional stray starts at T+5 and T+20
  task automatic run_op(input string tag, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input bit poke);
    int d0;
    d0 = done_cnt;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".busy_t1"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 32; i++) begin
      if (poke && (i == 5 || i == 20)) begin
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
      end
      step();
      start = 1'b0;
    end
    check({tag, ".done_t32"}, 32'(done), 32'd0);
    check({tag, ".busy_t32"}, 32'(busy), 32'd1);
    step();
    check({tag, ".done_t33"}, 32'(done), 32'd1);
    check({tag, ".busy_t33"}, 32'(busy), 32'd1);
    check({tag, ".quo"}, quotient, eq);
    check({tag, ".rem"}, remainder, er);
    step();
    check({tag, ".done_t34"}, 32'(done), 32'd0);
    check({tag, ".busy_t34"}, 32'(busy), 32'd0);
    check({tag, ".npulse"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    n_cmp     = 0;
    n_bad     = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    cancel    = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.quo", quotient, 32'd0);
    check("rst.rem", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
           32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("divu_dz", 1'b0, 32'h1234_5678, 32'd0,
           32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    run_op("div_dz", 1'b1, 32'h1234_5678, 32'd0,
           32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    run_op("div_dz_neg", 1'b1, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 32'd0, 1'b0);
    run_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 1'b0);
    run_op("poke_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);
    run_op("after_poke", 1'b1, 32'hFFFF_FF9C, 32'd7,
           32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    // cancel mid-CALC: no done, results hold
    d0        = done_cnt;
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd3;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 30; i++) step();
    check("cancel.npulse", 32'(done_cnt - d0), 32'd0);
    check("cancel.quo", quotient, 32'hFFFF_FFF2);
    check("cancel.rem", remainder, 32'hFFFF_FFFE);

    // cancel in IDLE blocks start
    start  = 1'b1;
    cancel = 1'b1;
    step();
    start  = 1'b0;
    cancel = 1'b0;
    check("idle_cancel.busy", 32'(busy), 32'd0);

    run_op("divu_100_7b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // async reset mid-op clears everything at once
    dividend = 32'd81;
    divisor  = 32'd9;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 14; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    check("arst.quo", quotient, 32'd0);
    check("arst.rem", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op("post_rst", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
